// File: rtl/br_mask_ctrl_pkg.sv
// Shared types and helpers for the R10K branch-mask controller.
// Mask width comes from `BR_MASK_W (default 4).
`ifndef BR_MASK_W
`define BR_MASK_W 4
`endif

package br_mask_ctrl_pkg;

  localparam int BR_NUM = `BR_MASK_W;
  localparam int IDX_W  = (BR_NUM > 1) ? $clog2(BR_NUM) : 1;

  typedef logic [BR_NUM-1:0] br_mask_t;
  typedef logic [IDX_W-1:0]  br_idx_t;

  // One-hot of the lowest-index clear bit; zero when every bit is set.
  function automatic br_mask_t lowest_zero(input br_mask_t m);
    br_mask_t res;
    logic     found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < BR_NUM; i++) begin
      if (!m[i] && !found) begin
        res[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic br_idx_t onehot_idx(input br_mask_t oh);
    br_idx_t idx;
    idx = '0;
    for (int i = 0; i < BR_NUM; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/br_mask_alloc.sv
// Lowest-free-tag picker: one-hot candidate tag and full flag from the occupancy mask.
module br_mask_alloc
  import br_mask_ctrl_pkg::*;
(
  input  br_mask_t mask_i,
  output br_mask_t pick_o,
  output logic     full_o
);

  assign pick_o = lowest_zero(mask_i);
  assign full_o = &mask_i;

endmodule

// File: rtl/br_mask_ctrl.sv
// Branch-mask controller: allocates one-hot branch tags, frees them on correct
// resolution and restores snapshots on misprediction. Optional BR_MASK_ERR_EN adds err_o.
module br_mask_ctrl
  import br_mask_ctrl_pkg::*;
#(
  parameter int BR_NUM = br_mask_ctrl_pkg::BR_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_br_i,
  input  logic              br_result_i,
  input  logic              br_right_i,
  input  logic [BR_NUM-1:0] br_bit_i,
  output logic [BR_NUM-1:0] br_mask_o,
  output logic [BR_NUM-1:0] br_dep_mask_o,
  output logic [BR_NUM-1:0] br_bit_o,
  output logic              full_o,
  output logic [BR_NUM-1:0] rc_sel_o,
  output logic [BR_NUM-1:0] squash_mask_o
`ifdef BR_MASK_ERR_EN
  ,
  output logic              err_o
`endif
);

  br_mask_t cur_q, cur_d;
  br_mask_t stack_q [BR_NUM];
  br_mask_t stack_d [BR_NUM];
  br_mask_t pick;
  br_idx_t  res_idx;
  logic     bad_res, res_ok, right_res, wrong_res, alloc;

`ifdef BR_MASK_ERR_EN
  logic err_q;
  // A resolution tag must be exactly one-hot and currently outstanding.
  assign bad_res = br_result_i &&
                   ((br_bit_i == '0) || ((br_bit_i & (br_bit_i - 1'b1)) != '0) ||
                    ((br_bit_i & cur_q) == '0));
  assign err_o   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | bad_res;
  end
`else
  assign bad_res = 1'b0;
`endif

  assign res_ok    = br_result_i && !bad_res;
  assign right_res = res_ok && br_right_i;
  assign wrong_res = res_ok && !br_right_i;
  assign res_idx   = onehot_idx(br_bit_i);

  br_mask_alloc u_alloc (
    .mask_i (cur_q),
    .pick_o (pick),
    .full_o (full_o)
  );

  // The pick comes from the registered mask, so a tag freed this cycle is never reused
  // until its entry has dropped mask_bit_i.
  assign alloc         = is_br_i && !full_o && !wrong_res;
  assign br_bit_o      = alloc ? pick : '0;
  assign br_dep_mask_o = right_res ? (cur_q & ~br_bit_i) : cur_q;
  assign br_mask_o     = cur_q;
  assign rc_sel_o      = wrong_res ? br_bit_i : '0;
  assign squash_mask_o = wrong_res ? (cur_q & ~stack_q[res_idx]) : '0;

  always_comb begin
    cur_d   = br_dep_mask_o | br_bit_o;
    stack_d = stack_q;
    if (wrong_res) cur_d = stack_q[res_idx];
    for (int i = 0; i < BR_NUM; i++) begin
      if (right_res)   stack_d[i] = stack_q[i] & ~br_bit_i;
      if (br_bit_o[i]) stack_d[i] = br_dep_mask_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= '0;
      for (int i = 0; i < BR_NUM; i++) stack_q[i] <= '0;
    end else begin
      cur_q   <= cur_d;
      stack_q <= stack_d;
    end
  end

endmodule

// File: tb/tb_br_mask_ctrl.sv
// Directed bench for br_mask_ctrl with BR_NUM = 4; err_o checks only with BR_MASK_ERR_EN.
module tb_br_mask_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       is_br_i = 1'b0;
  logic       br_result_i = 1'b0;
  logic       br_right_i = 1'b0;
  logic [3:0] br_bit_i = 4'b0000;
  logic [3:0] br_mask_o, br_dep_mask_o, br_bit_o, rc_sel_o, squash_mask_o;
  logic       full_o;
`ifdef BR_MASK_ERR_EN
  logic       err_o;
`endif

  int n_chk = 0;
  int n_err = 0;

  br_mask_ctrl #(.BR_NUM(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .is_br_i       (is_br_i),
    .br_result_i   (br_result_i),
    .br_right_i    (br_right_i),
    .br_bit_i      (br_bit_i),
    .br_mask_o     (br_mask_o),
    .br_dep_mask_o (br_dep_mask_o),
    .br_bit_o      (br_bit_o),
    .full_o        (full_o),
    .rc_sel_o      (rc_sel_o),
    .squash_mask_o (squash_mask_o)
`ifdef BR_MASK_ERR_EN
    ,
    .err_o         (err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drive inputs and let combinational outputs settle.
  task automatic drive(input logic br, input logic res, input logic right, input logic [3:0] bitv);
    is_br_i     = br;
    br_result_i = res;
    br_right_i  = right;
    br_bit_i    = bitv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    chk("rst_mask", br_mask_o, 4'b0000);
    chk("rst_full", {3'b000, full_o}, 4'b0000);
    rst = 1'b0;
    #1;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'b0000);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    logic [3:0] exp_m;
    #2;
    chk("rst_mask0", br_mask_o, 4'b0000);
    chk("rst_full0", {3'b000, full_o}, 4'b0000);
    chk("rst_bit0", br_bit_o, 4'b0000);
    chk("rst_rcsel0", rc_sel_o, 4'b0000);
    rst = 1'b0;
    tick();

    // Four back-to-back allocations fill the stack.
    exp_m = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 4'b0000);
      chk("alloc_bit", br_bit_o, 4'b0001 << i);
      chk("alloc_dep", br_dep_mask_o, exp_m);
      tick();
      exp_m = exp_m | (4'b0001 << i);
      chk("alloc_mask", br_mask_o, exp_m);
    end
    chk("full_set", {3'b000, full_o}, 4'b0001);
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    chk("full_bit", br_bit_o, 4'b0000);
    tick();
    chk("full_mask", br_mask_o, 4'b1111);
    do_reset();

    // Free a middle tag, reallocate it, then show its snapshot via misprediction.
    alloc_n(3);
    chk("s2_mask", br_mask_o, 4'b0111);
    drive(1'b0, 1'b1, 1'b1, 4'b0010);
    chk("s2_dep", br_dep_mask_o, 4'b0101);
    chk("s2_nosel", rc_sel_o, 4'b0000);
    tick();
    chk("s2_free", br_mask_o, 4'b0101);
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    chk("s2_realloc", br_bit_o, 4'b0010);
    tick();
    chk("s2_mask2", br_mask_o, 4'b0111);
    drive(1'b0, 1'b1, 1'b0, 4'b0010);
    chk("s2_sel", rc_sel_o, 4'b0010);
    chk("s2_squash", squash_mask_o, 4'b0010);
    tick();
    chk("s2_restore", br_mask_o, 4'b0101);
    do_reset();

    // Free and allocate in the same cycle: freed tag not eligible.
    alloc_n(2);
    drive(1'b1, 1'b1, 1'b1, 4'b0001);
    chk("s3_bit", br_bit_o, 4'b0100);
    chk("s3_dep", br_dep_mask_o, 4'b0010);
    tick();
    chk("s3_mask", br_mask_o, 4'b0110);
    drive(1'b0, 1'b1, 1'b0, 4'b0100);
    chk("s3_sel", rc_sel_o, 4'b0100);
    chk("s3_squash", squash_mask_o, 4'b0100);
    tick();
    chk("s3_restore", br_mask_o, 4'b0010);
    do_reset();

    // Misprediction with a concurrent dispatch.
    alloc_n(3);
    drive(1'b1, 1'b1, 1'b0, 4'b0010);
    chk("s4_sel", rc_sel_o, 4'b0010);
    chk("s4_squash", squash_mask_o, 4'b0110);
    chk("s4_nobit", br_bit_o, 4'b0000);
    tick();
    chk("s4_restore", br_mask_o, 4'b0001);
    do_reset();

    // Correct resolve of an older tag scrubs it from younger snapshots.
    alloc_n(3);
    drive(1'b0, 1'b1, 1'b1, 4'b0001);
    tick();
    chk("s5_mask", br_mask_o, 4'b0110);
    drive(1'b0, 1'b1, 1'b0, 4'b0010);
    chk("s5_squash", squash_mask_o, 4'b0110);
    tick();
    chk("s5_restore", br_mask_o, 4'b0000);
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    chk("s5_idle_sq", squash_mask_o, 4'b0000);

`ifdef BR_MASK_ERR_EN
    do_reset();
    alloc_n(1);
    chk("e_clear", {3'b000, err_o}, 4'b0000);
    drive(1'b0, 1'b1, 1'b1, 4'b0100);
    tick();
    chk("e_set", {3'b000, err_o}, 4'b0001);
    chk("e_mask", br_mask_o, 4'b0001);
    drive(1'b0, 1'b1, 1'b0, 4'b0011);
    chk("e_nohot_sel", rc_sel_o, 4'b0000);
    tick();
    chk("e_sticky", {3'b000, err_o}, 4'b0001);
    chk("e_mask2", br_mask_o, 4'b0001);
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    chk("e_async_err", {3'b000, err_o}, 4'b0000);
    chk("e_async_mask", br_mask_o, 4'b0000);
    rst = 1'b0;
`else
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    alloc_n(2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_mask", br_mask_o, 4'b0000);
    rst = 1'b0;
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
